pipeline_skid_register: RTL and testbench

PIPELINE_SKID_REGISTER -- requirements
Module: pipeline_skid_register

---
 rtl/pipeline_skid_register.sv | 120 ++++++++++++
 tb/tb_pipeline_skid_register.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_register.sv
// Two-entry skid register for a valid/ready pipeline stage: full throughput with
// in_ready and out_valid driven straight from flops, so no ready path crosses the stage.
module pipeline_skid_register #(
    parameter int DATA_WIDTH           = 128,
    parameter int CTRL_WIDTH           = 22,
    parameter bit CTRL_CLEAR_ON_BUBBLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [1:0]            occupancy
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_xfer;
    logic                  out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        // NOTE: every _d takes its held value first so no path through this block can infer a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_xfer && !in_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // A bubble must never present write enables downstream.
        if (CTRL_CLEAR_ON_BUBBLE && state_d == EMPTY) begin
            main_ctrl_d = '0;
        end

        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed and randomized checks of pipeline_skid_register against hand-computed
// values and a queue scoreboard.
module tb_pipeline_skid_register;

    localparam int DW = 128;
    localparam int CW = 22;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    int total = 0;
    int bad   = 0;

    entry_t sb_q[$];

    pipeline_skid_register #(
        .DATA_WIDTH(DW),
        .CTRL_WIDTH(CW),
        .CTRL_CLEAR_ON_BUBBLE(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the next falling edge samples the result.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_occ"},   occupancy, 0);
        check({tag, "_rdy"},   in_ready,  1);
        check({tag, "_ctrl"},  out_ctrl,  0);
    endtask

    initial begin
        entry_t        e;
        entry_t        exp_e;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [CW-1:0] prev_ctrl;
        logic          do_in;
        logic          do_out;

        reset = 1'b1;
        flush = 1'b0;
        drive(0, '0, '0, 0);
        tick();
        tick();
        check_idle("rst");
        check("rst_data", out_data, 0);

        // Streaming: first transfer on the first edge after reset drops.
        reset = 1'b0;
        drive(1, 128'h1, 22'h11, 1);
        tick();
        check("s1_data", out_data, 128'h1);
        check("s1_occ", occupancy, 1);
        check("s1_rdy", in_ready, 1);
        drive(1, 128'h2, 22'h12, 1);
        tick();
        check("s2_data", out_data, 128'h2);
        check("s2_occ", occupancy, 1);
        drive(1, 128'h3, 22'h13, 1);
        tick();
        check("s3_data", out_data, 128'h3);
        check("s3_ctrl", out_ctrl, 22'h13);
        check("s3_rdy", in_ready, 1);
        drive(0, '0, '0, 1);
        tick();
        check_idle("s_drain");
        check("s_hold_data", out_data, 128'h3);

        // Stall: A then B fill both registers, C offered while full is ignored.
        drive(1, 128'hA, 22'h1, 0);
        tick();
        check("st_a_occ", occupancy, 1);
        drive(1, 128'hB, 22'h2, 0);
        tick();
        check("st_b_occ", occupancy, 2);
        check("st_b_rdy", in_ready, 0);
        check("st_b_data", out_data, 128'hA);
        drive(1, 128'hC, 22'h3, 0);
        tick();
        check("st_c_occ", occupancy, 2);
        check("st_c_data", out_data, 128'hA);
        check("st_c_ctrl", out_ctrl, 22'h1);
        check("st_c_valid", out_valid, 1);
        drive(0, '0, '0, 1);
        tick();
        check("dr1_data", out_data, 128'hB);
        check("dr1_ctrl", out_ctrl, 22'h2);
        check("dr1_occ", occupancy, 1);
        check("dr1_rdy", in_ready, 1);
        tick();
        check_idle("dr0");

        // Flush while full with an input offered.
        drive(1, 128'hE, 22'h4, 0);
        tick();
        drive(1, 128'hF, 22'h5, 0);
        tick();
        check("fl_full_occ", occupancy, 2);
        flush = 1'b1;
        drive(1, 128'hC, 22'h6, 0);
        tick();
        flush = 1'b0;
        check_idle("fl");
        drive(1, 128'hD, 22'h7, 0);
        tick();
        check("fl_d_data", out_data, 128'hD);
        check("fl_d_ctrl", out_ctrl, 22'h7);
        check("fl_d_occ", occupancy, 1);
        drive(0, '0, '0, 1);
        tick();
        check_idle("fl_drain");

        // Reset together with flush and a live input transfer.
        drive(1, 128'h6, 22'h8, 0);
        tick();
        reset = 1'b1;
        flush = 1'b1;
        drive(1, 128'h7, 22'h9, 0);
        tick();
        reset = 1'b0;
        flush = 1'b0;
        check_idle("rf");
        check("rf_data", out_data, 0);

        // Reset mid-stall discards both held entries.
        drive(1, 128'h8, 22'hA, 0);
        tick();
        drive(1, 128'h9, 22'hB, 0);
        tick();
        check("rs_full_occ", occupancy, 2);
        reset = 1'b1;
        drive(0, '0, '0, 1);
        tick();
        reset = 1'b0;
        check_idle("rs");
        check("rs_data", out_data, 0);

        // Random traffic against a scoreboard queue.
        sb_q.delete();
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ctrl  = '0;
        for (int i = 0; i < 10000; i++) begin
            if (prev_stall) begin
                check("rnd_stall_valid", out_valid, 1);
                check("rnd_stall_data", out_data, prev_data);
                check("rnd_stall_ctrl", out_ctrl, prev_ctrl);
            end
            if (!out_valid) check("rnd_bubble_ctrl", out_ctrl, 0);
            e.data = {$urandom, $urandom, $urandom, $urandom};
            e.ctrl = CW'($urandom);
            drive(1'($urandom_range(0, 1)), e.data, e.ctrl, 1'($urandom_range(0, 1)));
            do_in  = in_valid && in_ready;
            do_out = out_valid && out_ready;
            if (do_out) begin
                if (sb_q.size() == 0) begin
                    check("rnd_underflow", sb_q.size(), 1);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("rnd_out_data", out_data, exp_e.data);
                    check("rnd_out_ctrl", out_ctrl, exp_e.ctrl);
                end
            end
            if (do_in) sb_q.push_back(e);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ctrl  = out_ctrl;
            tick();
            check("rnd_occ", occupancy, sb_q.size());
            check("rnd_rdy", in_ready, sb_q.size() != 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
